// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for the IF/ID buffer; master = fetch+decode side, slave = buffer.
// out_illegal exists only when ILLEGAL_TRAP_EN is defined.
interface if_id_buffer_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      out_immsrc;
`ifdef ILLEGAL_TRAP_EN
  logic            out_illegal;
`endif

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_immsrc
`ifdef ILLEGAL_TRAP_EN
    , out_illegal
`endif
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_immsrc
`ifdef ILLEGAL_TRAP_EN
    , out_illegal
`endif
  );
endinterface

// File: rtl/if_id_buffer.sv
// 2-entry fetch-to-decode skid buffer with opcode pre-decode of the immediate format.
// Optional ILLEGAL_TRAP_EN adds a per-entry illegal-instruction flag on out_illegal.
module if_id_buffer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic clk,
  input  logic reset,
  if_id_buffer_if.slave bus
);
  logic [XLEN-1:0] instr_q [2];
  logic [XLEN-1:0] pc_q    [2];
  logic [2:0]      imm_q   [2];
  logic [1:0]      count;
  logic            rd_ptr;
  logic            wr_ptr;
  logic            push;
  logic            pop;
  logic [2:0]      imm_dec;

  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    imm_dec = 3'b000;
    case (bus.in_instr[6:0])
      7'b0100011:             imm_dec = 3'b001;
      7'b1100011:             imm_dec = 3'b010;
      7'b1101111:             imm_dec = 3'b011;
      7'b0110111, 7'b0010111: imm_dec = 3'b100;
      default:                imm_dec = 3'b000;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic ill_q [2];
  logic ill_dec;

  always_comb begin
    ill_dec = 1'b1;
    case (bus.in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011,
      7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111,
      7'b0010111, 7'b0110011: ill_dec = 1'b0;
      default:                ill_dec = 1'b1;
    endcase
    if (bus.in_instr[1:0] != 2'b11) ill_dec = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ill_q[0] <= 1'b0;
      ill_q[1] <= 1'b0;
    end else if (push && !bus.flush) begin
      ill_q[wr_ptr] <= ill_dec;
    end
  end

  assign bus.out_illegal = bus.out_valid ? ill_q[rd_ptr] : 1'b0;
`else
  // Without the trap, unknown opcodes simply fall into the I-format default above.
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        imm_q[i]   <= 3'b000;
      end
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (bus.flush) begin
      // A pop this cycle still completes for decode; the push is dropped.
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= bus.in_instr;
        pc_q[wr_ptr]    <= bus.in_pc;
        imm_q[wr_ptr]   <= imm_dec;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.out_instr  = bus.out_valid ? instr_q[rd_ptr] : NOP_INSTR;
  assign bus.out_pc     = bus.out_valid ? pc_q[rd_ptr]    : '0;
  assign bus.out_immsrc = bus.out_valid ? imm_q[rd_ptr]   : 3'b000;
endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed steps then random traffic against a queue model.
// Build with ILLEGAL_TRAP_EN defined to also check out_illegal.
module tb_if_id_buffer;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  if_id_buffer_if #(.XLEN(32)) bus ();

  if_id_buffer #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] q_instr [$];
  logic [31:0] q_pc    [$];

  // Immediate format per opcode, as a lookup table.
  function automatic logic [2:0] exp_imm(input logic [31:0] w);
    logic [6:0] ops [9];
    logic [2:0] fmt [9];
    logic [6:0] op;
    logic [2:0] r;
    ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
    fmt = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    op = w[6:0];
    r  = 3'd0;
    for (int i = 0; i < 9; i++) if (ops[i] == op) r = fmt[i];
    return r;
  endfunction

`ifdef ILLEGAL_TRAP_EN
  function automatic logic exp_ill(input logic [31:0] w);
    logic [6:0] legal [10];
    logic       hit;
    logic [6:0] op;
    legal = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011,
              7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011};
    op  = w[6:0];
    hit = 1'b0;
    for (int i = 0; i < 10; i++) if (legal[i] == op) hit = 1'b1;
    return !hit || (w[1:0] != 2'b11);
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit ne;
    ne = (q_instr.size() != 0);
    chk("in_ready",   {31'b0, bus.in_ready},  {31'b0, q_instr.size() < 2});
    chk("out_valid",  {31'b0, bus.out_valid}, {31'b0, ne});
    chk("out_instr",  bus.out_instr,          ne ? q_instr[0] : NOP);
    chk("out_pc",     bus.out_pc,             ne ? q_pc[0] : 32'h0);
    chk("out_immsrc", {29'b0, bus.out_immsrc}, ne ? {29'b0, exp_imm(q_instr[0])} : 32'h0);
`ifdef ILLEGAL_TRAP_EN
    chk("out_illegal", {31'b0, bus.out_illegal}, ne ? {31'b0, exp_ill(q_instr[0])} : 32'h0);
`endif
  endtask

  // One clock: drive, check pre-edge outputs, advance model across the edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    bit do_push, do_pop;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    bus.flush     = fl;
    #1;
    check_outputs();
    do_push = v && (q_instr.size() < 2);
    do_pop  = rdy && (q_instr.size() != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      q_instr.delete();
      q_pc.delete();
    end else begin
      if (do_pop) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (do_push) begin
        q_instr.push_back(ins);
        q_pc.push_back(pc);
      end
    end
  endtask

  initial begin
    logic [6:0]  op_pool [12];
    logic [31:0] w;
    logic [31:0] pc;
    op_pool = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011, 7'b1111111, 7'b0000000};

    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    #1;
    check_outputs();
    #12 reset = 1'b1;
    @(posedge clk);
    #1;

    // Stream with decode always ready
    cycle(1'b1, 32'h0050_0093, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h0011_2223, 32'h4, 1'b1, 1'b0);
    cycle(1'b0, 32'h0,         32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0,         32'h0, 1'b1, 1'b0);

    // Back-pressure: third word is held by fetch until accepted
    cycle(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0011_2223, 32'h4, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE00_0EE3, 32'h8, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE00_0EE3, 32'h8, 1'b1, 1'b0);
    cycle(1'b1, 32'hFE00_0EE3, 32'h8, 1'b1, 1'b0);
    cycle(1'b0, 32'h0,         32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0,         32'h0, 1'b1, 1'b0);

    // Flush while full with a valid input present
    cycle(1'b1, 32'h0000_0013, 32'h10, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_0013, 32'h14, 1'b0, 1'b0);
    cycle(1'b1, 32'h0080_00EF, 32'h18, 1'b0, 1'b1);
    cycle(1'b0, 32'h0,         32'h0,  1'b1, 1'b0);

    // Decode sweep, plus an unknown opcode
    cycle(1'b1, 32'hFE00_0EE3, 32'h20, 1'b1, 1'b0);
    cycle(1'b1, 32'h0080_00EF, 32'h24, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_12B7, 32'h28, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0033, 32'h2C, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_007F, 32'h30, 1'b1, 1'b0);
    cycle(1'b0, 32'h0,         32'h0,  1'b1, 1'b0);
    cycle(1'b0, 32'h0,         32'h0,  1'b1, 1'b0);

    // Asynchronous reset with two entries, checked before any clock edge
    cycle(1'b1, 32'h0050_0093, 32'h40, 1'b0, 1'b0);
    cycle(1'b1, 32'h0011_2223, 32'h44, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    q_instr.delete();
    q_pc.delete();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Random traffic
    pc = 32'h100;
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      w[6:0] = op_pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) w[1:0] = 2'($urandom_range(0, 2));
      cycle($urandom_range(0, 3) != 0, w, pc, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      pc = pc + 32'd4;
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
